// File: rtl/rev_mult_seq_if.sv
// Operand/result handshake bundle for rev_mult_seq.
// master: the producer/consumer side. It offers dual-rail operands and accepts the product.
// slave : the multiplier side. It accepts operands and presents the dual-rail product.
// Signals:
//   in_valid/in_ready     operand handshake
//   a/a_not, b/b_not      dual-rail operands, WIDTH bits each
//   out_valid/out_ready   product handshake
//   p/p_not               dual-rail product, 2*WIDTH bits
interface rev_mult_seq_if #(
    parameter int unsigned WIDTH = 8
);
    logic                   in_valid;
    logic                   in_ready;
    logic [WIDTH-1:0]       a;
    logic [WIDTH-1:0]       a_not;
    logic [WIDTH-1:0]       b;
    logic [WIDTH-1:0]       b_not;
    logic                   out_valid;
    logic                   out_ready;
    logic [2*WIDTH-1:0]     p;
    logic [2*WIDTH-1:0]     p_not;

    modport master (
        output in_valid, a, a_not, b, b_not, out_ready,
        input  in_ready, out_valid, p, p_not
    );

    modport slave (
        input  in_valid, a, a_not, b, b_not, out_ready,
        output in_ready, out_valid, p, p_not
    );
endinterface

// File: rtl/rev_mult_seq.sv
// Sequential dual-rail multiplier with an optional reversible uncompute pass.
// The forward pass adds one shifted partial-product row per cycle. The product is then held
// on dual-rail outputs until it is accepted. With UNCOMPUTE=1 the rows are then subtracted
// in reverse order, which returns the accumulator to zero.
// Ports:
//   clk, rst_n   clock (rising edge) and asynchronous active-low reset
//   bus          rev_mult_seq_if.slave: operand and product handshakes, dual-rail data
//   busy         state is not IDLE
//   rail_err     sticky: an operand pair with an invalid rail pair was rejected
//   unc_done     1-cycle pulse when the uncompute pass finishes
//   unc_err      sticky: accumulator was nonzero at the end of the uncompute pass
module rev_mult_seq #(
    parameter int unsigned WIDTH     = 8,
    parameter bit          UNCOMPUTE = 1'b1
) (
    input  logic          clk,
    input  logic          rst_n,
    rev_mult_seq_if.slave bus,
    output logic          busy,
    output logic          rail_err,
    output logic          unc_done,
    output logic          unc_err
);
    localparam int unsigned PW = 2 * WIDTH;
    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CntMax = CW'(WIDTH - 1);

    typedef enum logic [1:0] {StIdle, StFwd, StHold, StBwd} state_e;

    state_e           state_q, state_d;
    logic [PW-1:0]    acc_q, acc_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             rail_err_q, rail_err_d;
    logic             unc_err_q, unc_err_d;
    logic             unc_done_q, unc_done_d;

    logic             rails_ok;
    logic [PW-1:0]    addend;

    // A rail pair is valid only when the two rails differ in every bit.
    assign rails_ok = (&(bus.a ^ bus.a_not)) & (&(bus.b ^ bus.b_not));

    // Row cnt of the partial-product array. The forward and backward passes share it.
    assign addend = b_q[cnt_q] ? ({{WIDTH{1'b0}}, a_q} << cnt_q) : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            acc_q      <= '0;
            a_q        <= '0;
            b_q        <= '0;
            cnt_q      <= '0;
            rail_err_q <= 1'b0;
            unc_err_q  <= 1'b0;
            unc_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            a_q        <= a_d;
            b_q        <= b_d;
            cnt_q      <= cnt_d;
            rail_err_q <= rail_err_d;
            unc_err_q  <= unc_err_d;
            unc_done_q <= unc_done_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        a_d        = a_q;
        b_d        = b_q;
        cnt_d      = cnt_q;
        rail_err_d = rail_err_q;
        unc_err_d  = unc_err_q;
        unc_done_d = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (bus.in_valid) begin
                    if (!rails_ok) begin
                        rail_err_d = 1'b1;
                    end else begin
                        a_d     = bus.a;
                        b_d     = bus.b;
                        acc_d   = '0;
                        cnt_d   = '0;
                        state_d = StFwd;
                    end
                end
            end
            StFwd: begin
                acc_d = acc_q + addend;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CntMax) begin
                    state_d = StHold;
                end
            end
            StHold: begin
                if (bus.out_ready) begin
                    if (UNCOMPUTE) begin
                        cnt_d   = CntMax;
                        state_d = StBwd;
                    end else begin
                        acc_d   = '0;
                        state_d = StIdle;
                    end
                end
            end
            StBwd: begin
                acc_d = acc_q - addend;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == '0) begin
                    state_d    = StIdle;
                    unc_done_d = 1'b1;
                    if (acc_d != '0) begin
                        unc_err_d = 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        // in_ready is gated by rst_n so that every output reads 0 while reset is held.
        bus.in_ready  = (state_q == StIdle) & rst_n;
        bus.out_valid = (state_q == StHold);
        // Outside HOLD both rails are 0, which is the null spacer.
        bus.p         = (state_q == StHold) ? acc_q : '0;
        bus.p_not     = (state_q == StHold) ? ~acc_q : '0;
        busy          = (state_q != StIdle);
        rail_err      = rail_err_q;
        unc_done      = unc_done_q;
        unc_err       = unc_err_q;
    end
endmodule
